risc_dmem_arbiter: RTL and testbench
====================================

Name: risc_dmem_arbiter

Overview:
- Shares the single 16x8 data memory between the CPU execute unit and an external host port (debug/loader).
- Sits between the eunit data-memory outputs (dmenbl, rdwr, dmaddr, dmdatain) and the memory.
- CPU has default priority. A starvation counter bounds host wait; the CPU is stalled for one cycle per host access.
- Memory read data (dmdataout) fans out unchanged to the register file; the arbiter only captures a copy for the host.

Parameters:
- ADDR_W, 4, data memory address width.
- DATA_W, 8, data width.
- HOST_MAX_WAIT, 4, consecutive CPU-busy cycles a pending host request tolerates before it is forced through (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_dmenbl  input  1  CPU memory access request (from eunit).
- cpu_rdwr  input  1  CPU direction: 1 = read, 0 = write.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_stall  output  1  CPU access not performed this cycle; eunit must hold its request.
- host_req  input  1  host request, level, held until host_ack.
- host_rdwr  input  1  host direction: 1 = read, 0 = write.
- host_addr  input  ADDR_W  host address.
- host_wdata  input  DATA_W  host write data.
- host_ack  output  1  one-cycle pulse: host access complete.
- host_rdata  output  DATA_W  registered host read data.
- dmenbl  output  1  memory enable.
- rdwr  output  1  memory direction: 1 = read, 0 = write.
- dmaddr  output  ADDR_W  memory address.
- dmdatain  output  DATA_W  memory write data.
- dmdataout  input  DATA_W  memory read data (synchronous read, 1-cycle latency).
- stat_host_cnt  output  8  host grant count (optional feature).
- stat_stall_cnt  output  8  CPU stall cycle count (optional feature).

Behaviour:
Reset (async, rst_n=0):
- state=S_CPU, wait_cnt=0, host_ack=0, host_rdata=0, latched host fields=0, stat counters=0.
- Memory outputs are combinational from the CPU inputs (S_CPU mux); cpu_stall=0.

State S_CPU:
- Memory is driven by the CPU: dmenbl=cpu_dmenbl; rdwr, dmaddr and dmdatain follow the CPU inputs. cpu_stall=0.
- If host_req=1 and (cpu_dmenbl=0 or wait_cnt==HOST_MAX_WAIT):
  - latch host_rdwr, host_addr and host_wdata;
  - clear wait_cnt;
  - next state S_HOST_ACC.
- Else if host_req=1 and cpu_dmenbl=1: wait_cnt increments, saturating at HOST_MAX_WAIT.
- Else (host_req=0): wait_cnt=0.

State S_HOST_ACC (exactly one cycle):
- Memory is driven by the latched host fields: dmenbl=1, rdwr=host_rdwr_q, dmaddr=host_addr_q, dmdatain=host_wdata_q.
- cpu_stall=cpu_dmenbl.
- Next state S_HOST_RSP.

State S_HOST_RSP (exactly one cycle):
- Memory is driven by the CPU, as in S_CPU; cpu_stall=0.
- host_ack=1.
- If host_rdwr_q=1, host_rdata<=dmdataout; for a write, host_rdata holds its previous value.
- Next state S_CPU. host_req is not sampled in this state.
- After host_ack the host drops host_req or presents a new request, which is sampled in S_CPU.

Timing and rules:
- Host latency: minimum 3 cycles from host_req rising to host_ack (S_CPU decision, S_HOST_ACC, S_HOST_RSP). Maximum is HOST_MAX_WAIT+3.
- The CPU loses at most 1 memory cycle per host transaction, and never stalls in two consecutive cycles.
- The eunit holds its request stable while cpu_stall=1; the stalled access is performed in the S_HOST_RSP cycle.
- Simultaneous CPU request and forced host grant: the CPU access completes in the decision cycle; the host wins the next cycle.
- Host fields are don't-care after latching; changing them mid-transaction has no effect.
- Reset mid-transaction: the host access is abandoned and no host_ack is issued. The host must re-request.

Optional Feature:
Macro RISC_DMEM_ARB_STATS_EN.
- Defined:
  - stat_host_cnt increments on each entry to S_HOST_ACC.
  - stat_stall_cnt increments on each cycle with cpu_stall=1.
  - Both counters are 8-bit, saturate at 255, and clear only on reset.
- Undefined: both ports are tied to 0 and no counter flops are generated.
- Ports exist in both builds.

Test Plan:
- Reset with host_req=1, cpu_dmenbl=0, then release rst_n -> S_CPU first. Host write to addr 0x5 with 0xA3 completes: host_ack pulses at cycle 3, mem shows dmenbl=1, rdwr=0, dmaddr=5, dmdatain=0xA3 in cycle 2. A later host read of 0x5 returns host_rdata=0xA3.
- CPU idle; host read addr 0xC with memory preloaded 0x3C -> host_ack at cycle 3, host_rdata=0x3C, cpu_stall never asserted.
- CPU continuous reads (cpu_dmenbl=1) with host_req held -> host forced after HOST_MAX_WAIT=4 busy cycles; exactly one cpu_stall cycle. The CPU's held address is presented to memory in the S_HOST_RSP cycle.
- Back-to-back host requests with continuous CPU traffic -> no two consecutive cpu_stall cycles; each host transaction gets exactly one host_ack.
- Assert rst_n=0 during S_HOST_ACC -> all outputs return to reset values, no host_ack. The re-issued request completes normally.
- With RISC_DMEM_ARB_STATS_EN: 3 forced host transactions under CPU load -> stat_host_cnt=3, stat_stall_cnt=3. After 300 grants, stat_host_cnt=255. Without the macro, both ports read 0.

Source files
------------

// File: rtl/risc_dmem_arbiter_if.sv
// Host (debug/loader) port of the data-memory arbiter: level request held until a one-cycle ack.
interface risc_dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              host_req;
  logic              host_rdwr;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_rdwr, host_addr, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_rdwr, host_addr, host_wdata,
    output host_ack, host_rdata
  );
endinterface

// File: rtl/risc_dmem_arbiter.sv
// Shares the 16x8 data memory between the CPU execute unit (default owner) and a host port.
// Optional statistics counters are built only when RISC_DMEM_ARB_STATS_EN is defined.
module risc_dmem_arbiter #(
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned HOST_MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_dmenbl,
  input  logic                 cpu_rdwr,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wdata,
  output logic                 cpu_stall,
  risc_dmem_arbiter_if.slave   host,
  output logic                 dmenbl,
  output logic                 rdwr,
  output logic [ADDR_W-1:0]    dmaddr,
  output logic [DATA_W-1:0]    dmdatain,
  input  logic [DATA_W-1:0]    dmdataout,
  output logic [7:0]           stat_host_cnt,
  output logic [7:0]           stat_stall_cnt
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned STAT_W = 8;

  typedef enum logic [1:0] {
    S_CPU      = 2'd0,
    S_HOST_ACC = 2'd1,
    S_HOST_RSP = 2'd2
  } state_t;

  state_t              state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                host_rdwr_q;
  logic [ADDR_W-1:0]   host_addr_q;
  logic [DATA_W-1:0]   host_wdata_q;
  logic                host_ack_q;
  logic [DATA_W-1:0]   host_rdata_q;
  logic                grant;

  // Host wins when the CPU is idle, or once it has waited out its starvation budget.
  assign grant = host.host_req &&
                 (!cpu_dmenbl || (wait_cnt == WAIT_W'(HOST_MAX_WAIT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_CPU;
      wait_cnt     <= '0;
      host_rdwr_q  <= 1'b0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      host_ack_q <= 1'b0;
      case (state)
        S_CPU: begin
          if (grant) begin
            host_rdwr_q  <= host.host_rdwr;
            host_addr_q  <= host.host_addr;
            host_wdata_q <= host.host_wdata;
            wait_cnt     <= '0;
            state        <= S_HOST_ACC;
          end else if (host.host_req) begin
            if (wait_cnt != WAIT_W'(HOST_MAX_WAIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        S_HOST_ACC: begin
          host_ack_q <= 1'b1;
          state      <= S_HOST_RSP;
        end
        S_HOST_RSP: begin
          // Synchronous memory: read data for the host access is valid this cycle.
          if (host_rdwr_q) host_rdata_q <= dmdataout;
          state <= S_CPU;
        end
        default: state <= S_CPU;
      endcase
    end
  end

  // Memory belongs to the CPU except during the single host access cycle.
  always_comb begin
    dmenbl    = cpu_dmenbl;
    rdwr      = cpu_rdwr;
    dmaddr    = cpu_addr;
    dmdatain  = cpu_wdata;
    cpu_stall = 1'b0;
    if (state == S_HOST_ACC) begin
      dmenbl    = 1'b1;
      rdwr      = host_rdwr_q;
      dmaddr    = host_addr_q;
      dmdatain  = host_wdata_q;
      cpu_stall = cpu_dmenbl;
    end
  end

  assign host.host_ack   = host_ack_q;
  assign host.host_rdata = host_rdata_q;

`ifdef RISC_DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] host_cnt_q;
  logic [STAT_W-1:0] stall_cnt_q;

  // Saturating grant and stall counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((state == S_CPU) && grant && (host_cnt_q != '1))
        host_cnt_q <= host_cnt_q + STAT_W'(1);
      if (cpu_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
    end
  end

  assign stat_host_cnt  = host_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_host_cnt  = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_risc_dmem_arbiter.sv
// Directed bench for risc_dmem_arbiter with a synchronous 16x8 memory model.
// Define RISC_DMEM_ARB_STATS_EN in both DUT and bench to check the statistics counters.
`timescale 1ns/1ps
module tb_risc_dmem_arbiter;

  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned HOST_MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_dmenbl;
  logic              cpu_rdwr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              dmenbl;
  logic              rdwr;
  logic [ADDR_W-1:0] dmaddr;
  logic [DATA_W-1:0] dmdatain;
  logic [DATA_W-1:0] dmdataout;
  logic [7:0]        stat_host_cnt;
  logic [7:0]        stat_stall_cnt;

  risc_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) h ();

  risc_dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_MAX_WAIT(HOST_MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_dmenbl(cpu_dmenbl), .cpu_rdwr(cpu_rdwr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .host(h),
    .dmenbl(dmenbl), .rdwr(rdwr), .dmaddr(dmaddr), .dmdatain(dmdatain),
    .dmdataout(dmdataout),
    .stat_host_cnt(stat_host_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory
  logic [DATA_W-1:0] mem [16];
  always @(posedge clk) begin
    if (dmenbl) begin
      if (rdwr) dmdataout <= mem[dmaddr];
      else      mem[dmaddr] <= dmdatain;
    end
  end

  int n_assert  = 0;
  int n_fail    = 0;
  int exp_host  = 0;
  int exp_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef RISC_DMEM_ARB_STATS_EN
    check({tag, "_host_cnt"}, stat_host_cnt, exp_host);
    check({tag, "_stall_cnt"}, stat_stall_cnt, exp_stall);
`else
    check({tag, "_host_cnt_off"}, stat_host_cnt, 0);
    check({tag, "_stall_cnt_off"}, stat_stall_cnt, 0);
`endif
  endtask

  // One host transaction with the CPU idle; starts in an S_CPU cycle and ends in the next one.
  task automatic host_idle_xact(input logic rw, input logic [3:0] a, input logic [7:0] d,
                                input logic [7:0] exp_rd);
    h.host_req = 1'b1; h.host_rdwr = rw; h.host_addr = a; h.host_wdata = d;
    #1;
    check("dec_ack", h.host_ack, 0);
    check("dec_stall", cpu_stall, 0);
    check("dec_dmenbl", dmenbl, 0);
    tick();
    check("acc_dmenbl", dmenbl, 1);
    check("acc_rdwr", rdwr, rw);
    check("acc_addr", dmaddr, a);
    if (!rw) check("acc_wdata", dmdatain, d);
    check("acc_stall", cpu_stall, 0);
    check("acc_ack", h.host_ack, 0);
    if (exp_host < 255) exp_host++;
    tick();
    check("rsp_ack", h.host_ack, 1);
    check("rsp_dmenbl", dmenbl, 0);
    h.host_req = 1'b0;
    tick();
    check("post_ack", h.host_ack, 0);
    check("post_rdata", h.host_rdata, exp_rd);
  endtask

  initial begin
    int acks;
    int stalls;
    int dbl;
    int ack_at [3];
    logic prev_stall;

    // Reset with a host request already pending
    rst_n = 1'b0;
    cpu_dmenbl = 1'b0; cpu_rdwr = 1'b1; cpu_addr = '0; cpu_wdata = '0;
    h.host_req = 1'b1; h.host_rdwr = 1'b0; h.host_addr = 4'h5; h.host_wdata = 8'hA3;
    repeat (3) tick();
    check("rst_ack", h.host_ack, 0);
    check("rst_rdata", h.host_rdata, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_dmenbl", dmenbl, 0);
    check_stats("rst");
    cpu_dmenbl = 1'b1; cpu_addr = 4'hE; cpu_wdata = 8'h99; cpu_rdwr = 1'b0;
    #1;
    check("rst_mux_en", dmenbl, 1);
    check("rst_mux_addr", dmaddr, 4'hE);
    check("rst_mux_wdata", dmdatain, 8'h99);
    cpu_dmenbl = 1'b0; cpu_rdwr = 1'b1;
    rst_n = 1'b1;
    #1;

    // First cycle after reset is the S_CPU decision cycle
    check("t1_dec_dmenbl", dmenbl, 0);
    check("t1_dec_ack", h.host_ack, 0);
    tick();
    h.host_addr = 4'h7; h.host_wdata = 8'h00;   // must not disturb the latched request
    #1;
    check("t1_acc_dmenbl", dmenbl, 1);
    check("t1_acc_rdwr", rdwr, 0);
    check("t1_acc_addr", dmaddr, 4'h5);
    check("t1_acc_wdata", dmdatain, 8'hA3);
    check("t1_acc_stall", cpu_stall, 0);
    exp_host++;
    tick();
    check("t1_rsp_ack", h.host_ack, 1);
    h.host_req = 1'b0;
    tick();
    check("t1_post_ack", h.host_ack, 0);
    check("t1_rdata_hold", h.host_rdata, 0);
    check("t1_mem5", mem[5], 8'hA3);

    // CPU write preloads address 0xC
    cpu_dmenbl = 1'b1; cpu_rdwr = 1'b0; cpu_addr = 4'hC; cpu_wdata = 8'h3C;
    #1;
    check("cpu_wr_addr", dmaddr, 4'hC);
    check("cpu_wr_data", dmdatain, 8'h3C);
    check("cpu_wr_rdwr", rdwr, 0);
    check("cpu_wr_stall", cpu_stall, 0);
    tick();
    cpu_dmenbl = 1'b0; cpu_rdwr = 1'b1;

    host_idle_xact(1'b1, 4'hC, 8'h00, 8'h3C);
    host_idle_xact(1'b1, 4'h5, 8'h00, 8'hA3);

    // Reset while the host access is on the memory bus
    h.host_req = 1'b1; h.host_rdwr = 1'b0; h.host_addr = 4'h6; h.host_wdata = 8'h77;
    tick();
    check("t5_acc_dmenbl", dmenbl, 1);
    check("t5_acc_addr", dmaddr, 4'h6);
    rst_n = 1'b0;
    #1;
    exp_host = 0; exp_stall = 0;
    check("t5_rst_dmenbl", dmenbl, 0);
    check("t5_rst_ack", h.host_ack, 0);
    check("t5_rst_rdata", h.host_rdata, 0);
    check("t5_rst_stall", cpu_stall, 0);
    check_stats("t5_rst");
    repeat (2) begin
      tick();
      check("t5_rst_hold_ack", h.host_ack, 0);
    end
    rst_n = 1'b1;
    host_idle_xact(1'b0, 4'h6, 8'h77, 8'h00);
    check("t5_mem6", mem[6], 8'h77);
    host_idle_xact(1'b1, 4'h6, 8'h00, 8'h77);

    // CPU streaming reads; host write is forced after HOST_MAX_WAIT busy cycles
    cpu_dmenbl = 1'b1; cpu_rdwr = 1'b1; cpu_addr = 4'h3;
    h.host_req = 1'b1; h.host_rdwr = 1'b0; h.host_addr = 4'h9; h.host_wdata = 8'h5A;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t3_wait_stall", cpu_stall, 0);
      check("t3_wait_ack", h.host_ack, 0);
      check("t3_wait_addr", dmaddr, 4'h3);
      tick();
    end
    check("t3_acc_stall", cpu_stall, 1);
    check("t3_acc_addr", dmaddr, 4'h9);
    check("t3_acc_rdwr", rdwr, 0);
    check("t3_acc_wdata", dmdatain, 8'h5A);
    exp_host++; exp_stall++;
    tick();
    check("t3_rsp_stall", cpu_stall, 0);
    check("t3_rsp_ack", h.host_ack, 1);
    check("t3_rsp_addr", dmaddr, 4'h3);
    check("t3_rsp_rdwr", rdwr, 1);
    h.host_req = 1'b0;
    tick();
    check("t3_post_ack", h.host_ack, 0);
    check("t3_post_stall", cpu_stall, 0);
    check("t3_mem9", mem[9], 8'h5A);
    check_stats("t3");

    // Back-to-back host writes under continuous CPU traffic
    h.host_req = 1'b1; h.host_rdwr = 1'b0; h.host_addr = 4'hA; h.host_wdata = 8'h40;
    #1;
    acks = 0; stalls = 0; dbl = 0; prev_stall = 1'b0;
    for (int k = 0; k < 3; k++) ack_at[k] = 0;
    for (int c = 0; c < 40; c++) begin
      if (cpu_stall && prev_stall) dbl++;
      if (cpu_stall) stalls++;
      prev_stall = cpu_stall;
      if (h.host_ack) begin
        if (acks < 3) ack_at[acks] = c;
        acks++;
        if (acks >= 3) h.host_req = 1'b0;
        else h.host_wdata = h.host_wdata + 8'h01;
      end
      tick();
    end
    check("t4_acks", acks, 3);
    check("t4_stalls", stalls, 3);
    check("t4_double_stall", dbl, 0);
    check("t4_ack0_cycle", ack_at[0], 6);
    check("t4_ack1_cycle", ack_at[1], 13);
    check("t4_ack2_cycle", ack_at[2], 20);
    check("t4_memA", mem[10], 8'h42);
    exp_host += 3; exp_stall += 3;
    cpu_dmenbl = 1'b0;
    check_stats("t4");

`ifdef RISC_DMEM_ARB_STATS_EN
    // Grant counter saturates at 255
    for (int n = 0; n < 300; n++) host_idle_xact(1'b1, 4'h5, 8'h00, 8'hA3);
    check("sat_host_cnt", stat_host_cnt, 255);
    check("sat_stall_cnt", stat_stall_cnt, exp_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
